erx_align: RTL and testbench
============================

Name: erx_align

Overview:
Receive-side link alignment controller for the eLink RX deserializer path.
- Sequences ISERDES reset release after RX enable.
- Trains word alignment by watching deserialized frame bytes and pulsing BITSLIP until each packet's frame start falls on the expected byte lane.
- Maintains lock status for ecfg readback.
- Sits in the rx_lclk_div4 domain, between the IO block's parallel frame output and its serdes RST/BITSLIP inputs.

Parameters:
RST_CYCLES, 8, cycles serdes_reset is held after enable/reset (minimum 2)
SLIP_WAIT, 4, cycles after a bitslip pulse during which frame data is ignored (covers ISERDES 2-cycle slip latency plus 2 output register stages)
LOCK_COUNT, 4, consecutive aligned frame starts needed to declare lock (1..15)
ERR_LIMIT, 2, consecutive misaligned frame starts in lock before lock is dropped (1..15)
ALIGN_PATTERN, 8'hFF, frame byte that marks an aligned start (bit 7 = first serial bit)

Ports:
rx_lclk_div4  in  1  parallel clock; all logic on its rising edge
reset  in  1  synchronous active-high reset
ecfg_rx_enable  in  1  RX enable; low forces RESET state
rx_frame_par  in  8  deserialized frame byte, one per cycle
serdes_reset  out  1  ISERDES reset, registered
rx_bitslip  out  1  one-cycle BITSLIP pulse, registered
rx_aligned  out  1  lock indication
ecfg_rx_slipcnt  out  3  bitslips issued since enable; wraps mod 8
ecfg_rx_align_err  out  1  sticky: 8 slips made without reaching lock
Conditional ports, present only with ERX_ALIGN_MANUAL_EN: ecfg_rx_manual in 1; ecfg_rx_slip_req in 1.

Behaviour:
- Reset is synchronous: when reset=1 or ecfg_rx_enable=0 at a clock edge, the next state is RST.
  - serdes_reset=1, rx_bitslip=0, rx_aligned=0, ecfg_rx_slipcnt=0, ecfg_rx_align_err=0.
  - All internal counters and history are cleared.
  - Deasserting enable mid-slip or mid-lock aborts immediately; no partial pulse.
- Start detection:
  - prev_zero is a register, set when the previous rx_frame_par == 8'h00.
  - start = prev_zero && rx_frame_par != 0.
  - aligned start: start && byte == ALIGN_PATTERN. Misaligned start: any other start.
  - Non-start bytes are ignored.
- States:
  - RST: serdes_reset=1. Counter runs RST_CYCLES cycles, then go to SEARCH; serdes_reset=0 from the first SEARCH cycle. prev_zero cleared.
  - SEARCH:
    - Aligned start: good_cnt++. If good_cnt reaches LOCK_COUNT, go to LOCKED; rx_aligned=1 the cycle after the completing start.
    - Misaligned start: good_cnt=0; go to SLIP.
  - SLIP (1 cycle):
    - rx_bitslip=1.
    - slipcnt increments. On wrap 7→0 without lock, set ecfg_rx_align_err.
    - Go to SETTLE.
  - SETTLE: SLIP_WAIT cycles, frame data ignored. prev_zero forced 0 on exit, so a fresh 8'h00 is required before the next start counts. Then go to SEARCH.
  - LOCKED: rx_aligned=1.
    - Aligned start: bad_cnt=0.
    - Misaligned start: bad_cnt++. At ERR_LIMIT, go to SEARCH with rx_aligned=0 the next cycle, good_cnt=0, bad_cnt=0. No slip in the same cycle; the next misaligned start in SEARCH slips.
- ecfg_rx_align_err stays set through lock; it clears only via reset/disable.
- Only one rx_bitslip pulse per SLIP+SETTLE window. Pulses are never back-to-back.
- All outputs are registered.
  - Start-to-rx_bitslip latency: 1 cycle.
  - Completing-start-to-rx_aligned latency: 1 cycle.

Optional Feature:
ERX_ALIGN_MANUAL_EN
- Defined:
  - With ecfg_rx_manual=1, automatic SEARCH/LOCKED decisions are suppressed; rx_aligned is held 0.
  - A rising edge of ecfg_rx_slip_req (edge-detected internally) in SEARCH or LOCKED triggers the SLIP→SETTLE sequence. Edges arriving during SLIP/SETTLE are dropped.
  - slipcnt and align_err update as in automatic mode.
  - Returning to ecfg_rx_manual=0 enters SEARCH with good_cnt=0.
- Undefined: the ports are absent; behaviour is automatic only.

Test Plan:
1. Reset 3 cycles, enable=1 → serdes_reset=1 for exactly 8 cycles after reset release; rx_bitslip=0 throughout.
2. Feed 4 packets {00,FF,FF,00} → rx_aligned=1 one cycle after the 4th FF start; slipcnt=0.
3. Feed start byte 8'h3F → rx_bitslip pulses 1 cycle after it, slipcnt=1. Starts during the next 4 cycles are ignored. Then 4 aligned starts → lock.
4. Only misaligned starts (8'h7F), 8 times → 8 single-cycle slip pulses, slipcnt wraps to 0, ecfg_rx_align_err=1 and stays 1 through a later lock.
5. Locked, then 2 consecutive 8'h1F starts → rx_aligned=0 after the 2nd. A single 1F followed by FF keeps the lock.
6. Drop ecfg_rx_enable during SETTLE → next cycle serdes_reset=1 and all status cleared. With ERX_ALIGN_MANUAL_EN: manual=1, one slip_req edge → exactly one rx_bitslip pulse.

Source files
------------

// File: rtl/erx_align_if.sv
// Grouped handshake/status signals between the eLink RX IO block, the ecfg
// registers and erx_align. ERX_ALIGN_MANUAL_EN adds the manual slip controls.
interface erx_align_if;
  logic       ecfg_rx_enable;
  logic [7:0] rx_frame_par;
  logic       serdes_reset;
  logic       rx_bitslip;
  logic       rx_aligned;
  logic [2:0] ecfg_rx_slipcnt;
  logic       ecfg_rx_align_err;
`ifdef ERX_ALIGN_MANUAL_EN
  logic       ecfg_rx_manual;
  logic       ecfg_rx_slip_req;

  modport master (
    output ecfg_rx_enable, rx_frame_par, ecfg_rx_manual, ecfg_rx_slip_req,
    input  serdes_reset, rx_bitslip, rx_aligned, ecfg_rx_slipcnt, ecfg_rx_align_err
  );

  modport slave (
    input  ecfg_rx_enable, rx_frame_par, ecfg_rx_manual, ecfg_rx_slip_req,
    output serdes_reset, rx_bitslip, rx_aligned, ecfg_rx_slipcnt, ecfg_rx_align_err
  );
`else
  modport master (
    output ecfg_rx_enable, rx_frame_par,
    input  serdes_reset, rx_bitslip, rx_aligned, ecfg_rx_slipcnt, ecfg_rx_align_err
  );

  modport slave (
    input  ecfg_rx_enable, rx_frame_par,
    output serdes_reset, rx_bitslip, rx_aligned, ecfg_rx_slipcnt, ecfg_rx_align_err
  );
`endif
endinterface

// File: rtl/erx_align.sv
// eLink RX word-alignment controller: ISERDES reset sequencing, BITSLIP training
// and lock tracking in the rx_lclk_div4 domain. Optional macro ERX_ALIGN_MANUAL_EN.
module erx_align #(
  parameter int         RST_CYCLES    = 8,
  parameter int         SLIP_WAIT     = 4,
  parameter int         LOCK_COUNT    = 4,
  parameter int         ERR_LIMIT     = 2,
  parameter logic [7:0] ALIGN_PATTERN = 8'hFF
) (
  input logic        rx_lclk_div4,
  input logic        reset,
  erx_align_if.slave bus
);

  localparam int CNT_MAX = (RST_CYCLES > SLIP_WAIT) ? RST_CYCLES : SLIP_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SLIP_WAIT - 1);
  localparam logic [3:0]       LOCK_LAST   = 4'(LOCK_COUNT - 1);
  localparam logic [3:0]       ERR_LAST    = 4'(ERR_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_SEARCH,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_good;
  logic [3:0]       r_bad;
  logic             r_prev_zero;
  logic             r_serdes_reset;
  logic             r_bitslip;
  logic             r_aligned;
  logic [2:0]       r_slipcnt;
  logic             r_align_err;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [3:0]       w_good;
  logic [3:0]       w_bad;
  logic             w_prev_zero;
  logic             w_serdes_reset;
  logic             w_bitslip;
  logic             w_aligned;
  logic [2:0]       w_slipcnt;
  logic             w_align_err;
  logic             w_enter_slip;

  logic             w_clear;
  logic             w_start;
  logic             w_aligned_start;
  logic             w_misaligned_start;
  logic             w_manual;
  logic             w_req_edge;

  // A packet starts on the first non-zero byte after an idle 8'h00 byte.
  assign w_clear            = reset || !bus.ecfg_rx_enable;
  assign w_start            = r_prev_zero && (bus.rx_frame_par != 8'h00);
  assign w_aligned_start    = w_start && (bus.rx_frame_par == ALIGN_PATTERN);
  assign w_misaligned_start = w_start && (bus.rx_frame_par != ALIGN_PATTERN);

`ifdef ERX_ALIGN_MANUAL_EN
  logic r_slip_req_d;

  always_ff @(posedge rx_lclk_div4) begin
    r_slip_req_d <= bus.ecfg_rx_slip_req;
  end

  assign w_manual   = bus.ecfg_rx_manual;
  assign w_req_edge = bus.ecfg_rx_slip_req && !r_slip_req_d;
`else
  assign w_manual   = 1'b0;
  assign w_req_edge = 1'b0;
`endif

  always_comb begin
    w_state        = r_state;
    w_cnt          = r_cnt;
    w_good         = r_good;
    w_bad          = r_bad;
    w_prev_zero    = (bus.rx_frame_par == 8'h00);
    w_serdes_reset = 1'b0;
    w_bitslip      = 1'b0;
    w_aligned      = 1'b0;
    w_slipcnt      = r_slipcnt;
    w_align_err    = r_align_err;
    w_enter_slip   = 1'b0;

    unique case (r_state)
      ST_RST: begin
        w_prev_zero = 1'b0;
        if (r_cnt == RST_LAST) begin
          w_state = ST_SEARCH;
          w_cnt   = '0;
        end else begin
          w_serdes_reset = 1'b1;
          w_cnt          = r_cnt + 1'b1;
        end
      end

      ST_SEARCH: begin
        if (w_manual) begin
          w_good       = '0;
          w_bad        = '0;
          w_enter_slip = w_req_edge;
        end else if (w_aligned_start) begin
          if (r_good == LOCK_LAST) begin
            w_state   = ST_LOCKED;
            w_good    = '0;
            w_bad     = '0;
            w_aligned = 1'b1;
          end else begin
            w_good = r_good + 1'b1;
          end
        end else if (w_misaligned_start) begin
          w_enter_slip = 1'b1;
        end
      end

      ST_LOCKED: begin
        if (w_manual) begin
          w_state      = ST_SEARCH;
          w_good       = '0;
          w_bad        = '0;
          w_enter_slip = w_req_edge;
        end else begin
          w_aligned = 1'b1;
          if (w_aligned_start) begin
            w_bad = '0;
          end else if (w_misaligned_start) begin
            // Losing lock only returns to SEARCH; the next bad start there slips.
            if (r_bad == ERR_LAST) begin
              w_state   = ST_SEARCH;
              w_aligned = 1'b0;
              w_good    = '0;
              w_bad     = '0;
            end else begin
              w_bad = r_bad + 1'b1;
            end
          end
        end
      end

      ST_SLIP: begin
        w_prev_zero = 1'b0;
        w_state     = ST_SETTLE;
        w_cnt       = '0;
      end

      ST_SETTLE: begin
        w_prev_zero = 1'b0;
        if (r_cnt == SETTLE_LAST) begin
          w_state = ST_SEARCH;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state        = ST_RST;
        w_cnt          = '0;
        w_prev_zero    = 1'b0;
        w_serdes_reset = 1'b1;
      end
    endcase

    // Every slip goes through here so the slip counter and sticky error stay in step.
    if (w_enter_slip) begin
      w_state     = ST_SLIP;
      w_bitslip   = 1'b1;
      w_prev_zero = 1'b0;
      w_good      = '0;
      w_bad       = '0;
      w_aligned   = 1'b0;
      w_slipcnt   = r_slipcnt + 3'd1;
      if (r_slipcnt == 3'd7) begin
        w_align_err = 1'b1;
      end
    end
  end

  always_ff @(posedge rx_lclk_div4) begin
    if (w_clear) begin
      r_state        <= ST_RST;
      r_cnt          <= '0;
      r_good         <= '0;
      r_bad          <= '0;
      r_prev_zero    <= 1'b0;
      r_serdes_reset <= 1'b1;
      r_bitslip      <= 1'b0;
      r_aligned      <= 1'b0;
      r_slipcnt      <= '0;
      r_align_err    <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      r_good         <= w_good;
      r_bad          <= w_bad;
      r_prev_zero    <= w_prev_zero;
      r_serdes_reset <= w_serdes_reset;
      r_bitslip      <= w_bitslip;
      r_aligned      <= w_aligned;
      r_slipcnt      <= w_slipcnt;
      r_align_err    <= w_align_err;
    end
  end

  assign bus.serdes_reset      = r_serdes_reset;
  assign bus.rx_bitslip        = r_bitslip;
  assign bus.rx_aligned        = r_aligned;
  assign bus.ecfg_rx_slipcnt   = r_slipcnt;
  assign bus.ecfg_rx_align_err = r_align_err;

endmodule

// File: tb/tb_erx_align.sv
// Bench for erx_align: directed alignment scenarios, then randomized frame
// bytes, all compared every cycle against a behavioural model of the link.
module tb_erx_align;

  localparam int         RST_CYCLES = 8;
  localparam int         SLIP_WAIT  = 4;
  localparam int         LOCK_COUNT = 4;
  localparam int         ERR_LIMIT  = 2;
  localparam logic [7:0] PAT        = 8'hFF;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   cmp_en   = 0;

  erx_align_if bus();

  erx_align #(
    .RST_CYCLES   (RST_CYCLES),
    .SLIP_WAIT    (SLIP_WAIT),
    .LOCK_COUNT   (LOCK_COUNT),
    .ERR_LIMIT    (ERR_LIMIT),
    .ALIGN_PATTERN(PAT)
  ) dut (
    .rx_lclk_div4(clk),
    .reset       (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: remaining reset cycles, remaining blind cycles after a
  // slip, lock flag, run counters and a running total of slips.
  int m_rst_left = 0;
  int m_block    = 0;
  int m_good     = 0;
  int m_bad      = 0;
  int m_slips    = 0;
  bit m_locked   = 0;
  bit m_prev_zero = 0;
  bit e_bitslip  = 0;
  bit e_err      = 0;

  task automatic model_step(input logic r, input logic en, input logic [7:0] b);
    bit st;
    e_bitslip = 0;
    if (r || !en) begin
      m_rst_left  = RST_CYCLES;
      m_block     = 0;
      m_good      = 0;
      m_bad       = 0;
      m_slips     = 0;
      m_locked    = 0;
      m_prev_zero = 0;
      e_err       = 0;
    end else if (m_rst_left > 0) begin
      m_rst_left--;
      m_prev_zero = 0;
    end else if (m_block > 0) begin
      m_block--;
      m_prev_zero = 0;
    end else begin
      st = m_prev_zero && (b != 8'h00);
      m_prev_zero = (b == 8'h00);
      if (st && m_locked) begin
        if (b == PAT) m_bad = 0;
        else begin
          m_bad++;
          if (m_bad == ERR_LIMIT) begin
            m_locked = 0;
            m_bad    = 0;
            m_good   = 0;
          end
        end
      end else if (st) begin
        if (b == PAT) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin
            m_locked = 1;
            m_good   = 0;
          end
        end else begin
          m_good    = 0;
          m_slips++;
          e_bitslip = 1;
          if (m_slips >= 8) e_err = 1;
          m_block   = 1 + SLIP_WAIT;
        end
      end
    end
  endtask

  always @(posedge clk) model_step(rst, bus.ecfg_rx_enable, bus.rx_frame_par);

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model serdes_reset", 8'(bus.serdes_reset), 8'(m_rst_left > 0));
      check("model rx_bitslip", 8'(bus.rx_bitslip), 8'(e_bitslip));
      check("model rx_aligned", 8'(bus.rx_aligned), 8'(m_locked));
      check("model slipcnt", 8'(bus.ecfg_rx_slipcnt), 8'(m_slips % 8));
      check("model align_err", 8'(bus.ecfg_rx_align_err), 8'(e_err));
    end
  end

  task automatic tick(input logic [7:0] b);
    bus.rx_frame_par = b;
    @(negedge clk);
  endtask

  task automatic packet(input logic [7:0] b);
    tick(8'h00);
    tick(b);
    tick(b);
    tick(8'h00);
  endtask

  task automatic restart();
    bus.ecfg_rx_enable = 1'b0;
    tick(8'h00);
    bus.ecfg_rx_enable = 1'b1;
    repeat (RST_CYCLES) tick(8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt;
    bit         slip_seen;
    logic [7:0] b;
    int         r;
    int         pulses;

    rst = 1'b1;
    bus.ecfg_rx_enable = 1'b1;
    bus.rx_frame_par   = 8'h00;
`ifdef ERX_ALIGN_MANUAL_EN
    bus.ecfg_rx_manual   = 1'b0;
    bus.ecfg_rx_slip_req = 1'b0;
`endif
    @(negedge clk);
    cmp_en = 1;
    tick(8'h00);
    tick(8'h00);
    rst = 1'b0;

    // Reset release: serdes_reset held for RST_CYCLES cycles, no slips
    cnt = 0;
    slip_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rx_bitslip) slip_seen = 1;
      if (!bus.serdes_reset) break;
      cnt++;
      tick(8'h00);
    end
    check("serdes_reset high cycles", 8'(cnt), 8'd8);
    check("no bitslip in reset", 8'(slip_seen), 8'd0);

    // Four aligned packets reach lock right after the fourth start
    for (int p = 0; p < 4; p++) begin
      tick(8'h00);
      tick(8'hFF);
      check("aligned after start", 8'(bus.rx_aligned), (p == 3) ? 8'd1 : 8'd0);
      tick(8'hFF);
      tick(8'h00);
    end
    check("slipcnt after lock", 8'(bus.ecfg_rx_slipcnt), 8'd0);

    // One bad start followed by a good one keeps lock; two in a row drop it
    tick(8'h00); tick(8'h1F); tick(8'h00); tick(8'hFF);
    check("lock kept after single 1F", 8'(bus.rx_aligned), 8'd1);
    tick(8'h00); tick(8'h1F);
    check("lock kept after first 1F", 8'(bus.rx_aligned), 8'd1);
    tick(8'h00); tick(8'h1F);
    check("lock lost after second 1F", 8'(bus.rx_aligned), 8'd0);
    check("no slip on lock loss", 8'(bus.rx_bitslip), 8'd0);

    // Misaligned 3F start slips once, then the blind window ignores starts
    tick(8'h00); tick(8'h3F);
    check("bitslip after 3F", 8'(bus.rx_bitslip), 8'd1);
    check("slipcnt after 3F", 8'(bus.ecfg_rx_slipcnt), 8'd1);
    tick(8'h00);
    check("bitslip single cycle", 8'(bus.rx_bitslip), 8'd0);
    tick(8'hFF); tick(8'h00); tick(8'hFF);
    check("slipcnt after window", 8'(bus.ecfg_rx_slipcnt), 8'd1);
    tick(8'h00);
    for (int p = 0; p < 4; p++) packet(8'hFF);
    check("relock after slip", 8'(bus.rx_aligned), 8'd1);

    // Eight misaligned starts wrap slipcnt and set the sticky error
    restart();
    for (int i = 0; i < 8; i++) begin
      tick(8'h00);
      tick(8'h7F);
      check("bitslip on 7F", 8'(bus.rx_bitslip), 8'd1);
      if (i == 6) check("align_err before wrap", 8'(bus.ecfg_rx_align_err), 8'd0);
      repeat (5) tick(8'h00);
    end
    check("slipcnt wrapped", 8'(bus.ecfg_rx_slipcnt), 8'd0);
    check("align_err set", 8'(bus.ecfg_rx_align_err), 8'd1);
    for (int p = 0; p < 4; p++) packet(8'hFF);
    check("lock after wrap", 8'(bus.rx_aligned), 8'd1);
    check("align_err sticky in lock", 8'(bus.ecfg_rx_align_err), 8'd1);

    // Disable during SETTLE clears everything on the next cycle
    tick(8'h00); tick(8'h1F); tick(8'h00); tick(8'h1F);
    tick(8'h00); tick(8'h3F);
    check("slipcnt before disable", 8'(bus.ecfg_rx_slipcnt), 8'd1);
    tick(8'h00); tick(8'h00);
    bus.ecfg_rx_enable = 1'b0;
    tick(8'h00);
    check("disable serdes_reset", 8'(bus.serdes_reset), 8'd1);
    check("disable slipcnt", 8'(bus.ecfg_rx_slipcnt), 8'd0);
    check("disable align_err", 8'(bus.ecfg_rx_align_err), 8'd0);
    check("disable bitslip", 8'(bus.rx_bitslip), 8'd0);
    bus.ecfg_rx_enable = 1'b1;
    repeat (RST_CYCLES) tick(8'h00);

    // Randomized traffic: mostly clean first, then noisier
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) b = 8'h00;
      else if (r < ((i < 1500) ? 92 : 72)) b = PAT;
      else if (r < 80) b = 8'h3F;
      else if (r < 88) b = 8'h7F;
      else if (r < 94) b = 8'h1F;
      else b = 8'($urandom);
      bus.ecfg_rx_enable = ($urandom_range(0, 499) != 0);
      rst = ($urandom_range(0, 1499) == 0);
      tick(b);
    end
    rst = 1'b0;
    bus.ecfg_rx_enable = 1'b1;
    tick(8'h00);

`ifdef ERX_ALIGN_MANUAL_EN
    // Manual mode: bad starts are ignored, one request edge gives one pulse
    cmp_en = 0;
    bus.ecfg_rx_manual = 1'b1;
    restart();
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      bus.ecfg_rx_slip_req = (j != 2);
      tick((j % 2 == 0) ? 8'h00 : 8'h3F);
      if (bus.rx_bitslip) pulses++;
    end
    check("manual single pulse", 8'(pulses), 8'd1);
    check("manual slipcnt", 8'(bus.ecfg_rx_slipcnt), 8'd1);
    for (int p = 0; p < 4; p++) packet(8'hFF);
    check("manual holds aligned low", 8'(bus.rx_aligned), 8'd0);
    bus.ecfg_rx_manual   = 1'b0;
    bus.ecfg_rx_slip_req = 1'b0;
    rst = 1'b1;
    tick(8'h00);
    cmp_en = 1;
    rst = 1'b0;
    repeat (RST_CYCLES) tick(8'h00);
    for (int p = 0; p < 4; p++) packet(8'hFF);
`else
    pulses = 0;
    for (int p = 0; p < 4; p++) packet(8'hFF);
    if (bus.rx_bitslip) pulses++;
    check("no stray pulse at end", 8'(pulses), 8'd0);
`endif
    tick(8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
